wb_conbus_rr: RTL
=================

Name: wb_conbus_rr

Overview:
- Parametrised shared-bus Wishbone interconnect: N_M masters, N_S slaves, one owner at a time.
- Generalises the fixed 8x8 conbus with these additions:
  - round-robin arbitration with bus hold while the owner keeps cyc high;
  - per-slave base/mask address decode;
  - error response for unmapped addresses;
  - watchdog timeout that terminates hung cycles with err.
- Sits between the lm32 I/D ports (plus future DMA masters) and bram/ddr/uart/timer slaves.

Parameters:
- N_M, 2, number of masters (1..8).
- N_S, 4, number of slaves (1..8).
- S_BASE, {N_S{32'h0}}, packed N_S*32; slave j base address in bits [32j+31:32j].
- S_MASK, {N_S{32'hF0000000}}, packed N_S*32; slave j matches when (adr & mask_j) == base_j.
- TIMEOUT, 255, cycles of unanswered stb before forced err; 0 disables the watchdog.
- TW, 8, width of the timeout counter; TIMEOUT must be below 2**TW.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m_adr_i  in  N_M*32  master addresses
- m_dat_i  in  N_M*32  master write data
- m_sel_i  in  N_M*4  byte selects
- m_we_i  in  N_M  write enables
- m_cyc_i  in  N_M  cycle requests
- m_stb_i  in  N_M  strobes
- m_dat_o  out  32  read data, broadcast to all masters
- m_ack_o  out  N_M  acknowledges
- m_err_o  out  N_M  error responses
- m_rty_o  out  N_M  retry responses
- s_adr_o  out  32  shared slave address
- s_dat_o  out  32  shared slave write data
- s_sel_o  out  4  shared byte selects
- s_we_o  out  1  shared write enable
- s_cyc_o  out  N_S  per-slave cycle
- s_stb_o  out  N_S  per-slave strobe
- s_dat_i  in  N_S*32  slave read data
- s_ack_i  in  N_S  slave acknowledges
- s_err_i  in  N_S  slave errors
- s_rty_i  in  N_S  slave retries
- grant_o  out  N_M  one-hot current owner (debug/probe)
- timeout_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
Clock and reset:
- Single clock clk; reset_n is asynchronous and active-low.

Reset:
- grant = 0, state IDLE, last = N_M-1, watchdog count = 0, err_pend = 0.
- All outputs 0, including s_adr_o and s_dat_o.
- Asserting reset mid-cycle drops ownership immediately; no ack/err is produced for the aborted transfer.

Arbiter FSM, states IDLE and OWN:
- IDLE -> OWN: when any m_cyc_i is high, grant the first requester scanning from (last+1) mod N_M upward with wrap-around. Register grant and set last = winner.
- OWN: owner's signals are forwarded combinationally.
- OWN -> IDLE: when the owner's cyc is low. The transition is registered, so there is one dead cycle between owners.
- Owner may hold cyc across any number of strobes (bursts, locked RMW); no preemption.
- N_M = 1: the arbiter degenerates, but the dead cycle is kept.

Decode (combinational, from the owner's adr):
- hit[j] = ((adr & S_MASK_j) == S_BASE_j); the lowest index j wins when ranges overlap.
- s_cyc_o[j] = OWN & owner cyc & sel[j].
- s_stb_o[j] = OWN & owner stb & sel[j].
- s_adr_o, s_dat_o, s_sel_o, s_we_o come from the owner; they are 0 in IDLE.

Response routing:
- Owner receives the selected slave's ack/err/rty combinationally, i.e. zero added latency.
- Non-owners always see ack/err/rty = 0.
- m_dat_o = selected slave's dat; 0 when unmapped.

Unmapped address:
- Owner stb high with no hit: err_pend is set, and m_err_o[owner] pulses exactly one cycle on the next cycle.
- err_pend clears the cycle the err is issued; if stb stays high, the next err follows 2 cycles later.

Watchdog:
- Counts while owner stb is high, the address is mapped and no ack/err/rty has arrived.
- Clears on any response, on stb low, or in IDLE.
- On reaching TIMEOUT: m_err_o[owner] and timeout_o pulse for one cycle and the count clears.
- A slave response arriving in the same cycle as expiry wins; no err and no timeout_o in that case.

Simultaneous events:
- A new request arriving the same cycle the owner releases is arbitrated in the following IDLE cycle.
- A request arriving during OWN waits; it is not lost.

Decomposition:
- Package wb_conbus_pkg: state encoding (IDLE, OWN), and the helper function rr_pick(req, last) returning a one-hot grant.
- Optional sub-module wb_rr_arbiter: request vector, last pointer and grant register.
- Decode, muxing and watchdog stay in the top module.

Test Plan:
- N_M=2, both masters raise cyc together after reset -> grant_o=2'b01 first. M0 drops cyc -> one IDLE cycle, then grant_o=2'b10. M0 re-requests -> granted after M1 releases.
- Slave 1 base 32'h40000000, mask 32'hF0000000. M0 reads 32'h40000010, slave acks next cycle with 32'hDEADBEEF -> s_stb_o=4'b0010 and m_ack_o[0] coincident with s_ack_i[1]. m_dat_o=32'hDEADBEEF; m_ack_o[1] stays 0.
- M1 accesses 32'h90000000 (unmapped) -> m_err_o[1] high exactly one cycle, one cycle after stb. All s_stb_o stay 0.
- TIMEOUT=8, mapped slave never responds -> timeout_o and m_err_o[owner] high on cycle 8 of stb. Repeats every 8 cycles while stb is held.
- M0 holds cyc over 4 strobes while M1 requests -> grant_o stays 2'b01 for all 4 acks. M1 is granted only after M0's cyc falls.
- reset_n pulsed low mid-transfer -> all outputs 0 asynchronously. After release, the pending request is re-arbitrated from IDLE.

Source files
------------

// File: rtl/wb_conbus_pkg.sv
// Shared definitions for the round-robin Wishbone shared-bus interconnect:
// arbiter state encoding and the round-robin pick helper.
package wb_conbus_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_OWN  = 1'b1;

   // One-hot grant for the first set bit of req scanning upward from last+1.
   // Unused upper request bits must be zero; the 3-bit wrap then matches mod N_M.
   function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] last);
      logic [7:0] g;
      logic [2:0] idx;
      g = '0;
      for (int k = 8; k >= 1; k--) begin
         idx = last + 3'(k);
         if (req[idx]) begin
            g = '0;
            g[idx] = 1'b1;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin bus-ownership arbiter: grants one cyc requester from IDLE and
// holds the grant until the owner drops cyc, then inserts one IDLE cycle.
module wb_rr_arbiter
   import wb_conbus_pkg::*;
#(
   parameter int N_M = 2
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [N_M-1:0] req,
   output logic [N_M-1:0] grant,
   output logic [0:0]     state
);

   logic [2:0] last;
   logic [7:0] pick;
   logic [2:0] pick_idx;

   assign pick = rr_pick(8'(req), last);

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (pick[i]) pick_idx = 3'(i);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         grant <= '0;
         last  <= 3'(N_M - 1);
      end else if (state == ST_IDLE) begin
         if (|req) begin
            state <= ST_OWN;
            grant <= pick[N_M-1:0];
            last  <= pick_idx;
         end
      end else if (!(|(req & grant))) begin
         state <= ST_IDLE;
         grant <= '0;
      end
   end

endmodule

// File: rtl/wb_conbus_rr.sv
// N_M x N_S shared-bus Wishbone interconnect: round-robin ownership, base/mask
// decode, err for unmapped addresses and a watchdog that errs out hung strobes.
module wb_conbus_rr
   import wb_conbus_pkg::*;
#(
   parameter int                N_M     = 2,
   parameter int                N_S     = 4,
   parameter logic [N_S*32-1:0] S_BASE  = {N_S{32'h0}},
   parameter logic [N_S*32-1:0] S_MASK  = {N_S{32'hF0000000}},
   parameter int                TIMEOUT = 255,
   parameter int                TW      = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [N_M*32-1:0] m_adr_i,
   input  logic [N_M*32-1:0] m_dat_i,
   input  logic [N_M*4-1:0]  m_sel_i,
   input  logic [N_M-1:0]    m_we_i,
   input  logic [N_M-1:0]    m_cyc_i,
   input  logic [N_M-1:0]    m_stb_i,
   output logic [31:0]       m_dat_o,
   output logic [N_M-1:0]    m_ack_o,
   output logic [N_M-1:0]    m_err_o,
   output logic [N_M-1:0]    m_rty_o,
   output logic [31:0]       s_adr_o,
   output logic [31:0]       s_dat_o,
   output logic [3:0]        s_sel_o,
   output logic              s_we_o,
   output logic [N_S-1:0]    s_cyc_o,
   output logic [N_S-1:0]    s_stb_o,
   input  logic [N_S*32-1:0] s_dat_i,
   input  logic [N_S-1:0]    s_ack_i,
   input  logic [N_S-1:0]    s_err_i,
   input  logic [N_S-1:0]    s_rty_i,
   output logic [N_M-1:0]    grant_o,
   output logic              timeout_o
);

   localparam logic [TW-1:0] WD_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   logic [N_M-1:0] grant;
   logic [0:0]     state;
   logic           own;

   wb_rr_arbiter #(.N_M(N_M)) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (m_cyc_i),
      .grant   (grant),
      .state   (state)
   );

   assign own     = (state == ST_OWN);
   assign grant_o = grant;

   // Owner mux; grant is all-zero in IDLE so every forwarded field reads 0 there.
   logic [31:0] o_adr, o_dat;
   logic [3:0]  o_sel;
   logic        o_we, o_cyc, o_stb;

   always_comb begin
      o_adr = '0;
      o_dat = '0;
      o_sel = '0;
      o_we  = 1'b0;
      o_cyc = 1'b0;
      o_stb = 1'b0;
      for (int i = 0; i < N_M; i++) begin
         if (grant[i]) begin
            o_adr = m_adr_i[32*i +: 32];
            o_dat = m_dat_i[32*i +: 32];
            o_sel = m_sel_i[4*i +: 4];
            o_we  = m_we_i[i];
            o_cyc = m_cyc_i[i];
            o_stb = m_stb_i[i];
         end
      end
   end

   // Descending scan so the lowest matching slave index wins on overlap.
   logic [N_S-1:0] sel;
   logic           mapped;

   always_comb begin
      sel = '0;
      for (int j = N_S - 1; j >= 0; j--) begin
         if (own && ((o_adr & S_MASK[32*j +: 32]) == S_BASE[32*j +: 32])) begin
            sel    = '0;
            sel[j] = 1'b1;
         end
      end
      mapped = |sel;
   end

   assign s_adr_o = o_adr;
   assign s_dat_o = o_dat;
   assign s_sel_o = o_sel;
   assign s_we_o  = o_we;
   assign s_cyc_o = {N_S{o_cyc}} & sel;
   assign s_stb_o = {N_S{o_stb}} & sel;

   logic [31:0] r_dat;
   logic        r_ack, r_err, r_rty;

   always_comb begin
      r_dat = '0;
      r_ack = 1'b0;
      r_err = 1'b0;
      r_rty = 1'b0;
      for (int j = 0; j < N_S; j++) begin
         if (sel[j]) begin
            r_dat = s_dat_i[32*j +: 32];
            r_ack = s_ack_i[j];
            r_err = s_err_i[j];
            r_rty = s_rty_i[j];
         end
      end
   end

   logic [TW-1:0] wd_cnt;
   logic          err_pend;
   logic          wd_run, wd_exp;

   // A response in the expiry cycle drops wd_run, so the slave always wins.
   assign wd_run = o_stb & mapped & ~(r_ack | r_err | r_rty);
   assign wd_exp = (TIMEOUT != 0) && wd_run && (wd_cnt == WD_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_cnt   <= '0;
         err_pend <= 1'b0;
      end else begin
         wd_cnt   <= (wd_run && !wd_exp) ? wd_cnt + TW'(1) : '0;
         err_pend <= err_pend ? 1'b0 : (o_stb & ~mapped);
      end
   end

   assign m_dat_o   = r_dat;
   assign m_ack_o   = {N_M{r_ack}} & grant;
   assign m_rty_o   = {N_M{r_rty}} & grant;
   assign m_err_o   = {N_M{r_err | err_pend | wd_exp}} & grant;
   assign timeout_o = wd_exp;

endmodule
